idiv_wb_buffer: RTL and testbench
=================================

Name: idiv_wb_buffer

Overview:
- Sits directly downstream of the iterative integer divider.
- Consumes its valid/rd/result stream and issues the yumi back to it.
- Buffers up to els_p results and competes with the main pipeline for the single integer regfile write port. The pipeline has priority; an anti-starvation counter forces a one-cycle pipeline writeback stall.
- Also produces the scoreboard-clear for the destination register.

Parameters:
- data_width_p, reg_data_width_gp: result width.
- reg_addr_width_p, reg_addr_width_gp: destination register index width.
- els_p, 2: result queue depth. Must be ≥ 1.
- max_wait_p, 8: blocked cycles tolerated before stall_pipe_o asserts. Must be ≥ 1.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- idiv_v_i  in  1  divider result valid
- idiv_rd_i  in  reg_addr_width_p  divider destination register
- idiv_result_i  in  data_width_p  divider quotient/remainder
- idiv_yumi_o  out  1  result consumed this cycle
- pipe_wb_v_i  in  1  main pipeline owns the write port this cycle
- wb_v_o  out  1  buffer writes regfile this cycle
- wb_rd_o  out  reg_addr_width_p  write address
- wb_data_o  out  data_width_p  write data
- sb_clear_v_o  out  1  clear scoreboard bit for sb_clear_rd_o
- sb_clear_rd_o  out  reg_addr_width_p  register to clear
- stall_pipe_o  out  1  pipeline must not writeback next cycle
- empty_o  out  1  queue empty (used for fence/drain)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i; all state clears immediately when reset_n_i is low.
- Reset values: queue count 0, pointers 0, wait counter 0, stall_pipe_o 0, empty_o 1, wb_v_o 0, sb_clear_v_o 0, idiv_yumi_o 0. Data storage is not reset.
- Enqueue: idiv_yumi_o = idiv_v_i & (count < els_p).
  - Uses registered count only. A dequeue in the same cycle does not free a slot for that cycle's enqueue.
  - On yumi, {idiv_rd_i, idiv_result_i} is written at the write pointer.
- Dequeue (combinational from state): wb_v_o = ~empty & ~pipe_wb_v_i.
  - wb_rd_o/wb_data_o = head entry. They are driven from the head even when wb_v_o is 0; they must be 0 when empty.
  - On wb_v_o the read pointer advances.
- sb_clear_v_o = wb_v_o; sb_clear_rd_o = wb_rd_o. Clear and write are in the same cycle.
- Latency: an enqueued result is writable no earlier than the cycle after yumi. The minimum is 1 cycle, with no bypass.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Pointers: mod-els_p counters that wrap from els_p-1 to 0. For non-power-of-two els_p they use explicit compare. Count ranges 0..els_p.
- rd = 0: handled like any other entry (enqueued, written, cleared). The regfile ignores x0.
- Wait counter:
  - Increments when ~empty & pipe_wb_v_i.
  - Resets to 0 on any wb_v_o or when empty.
  - Saturates at max_wait_p.
- stall_pipe_o is registered: it is set in the cycle after the counter reaches max_wait_p with the queue still non-empty, and held until the next dequeue. It falls in the cycle after wb_v_o.
- Protocol: while stall_pipe_o=1 the pipeline must deassert pipe_wb_v_i.
  - If it does not, the pipeline still wins.
  - A simulation assertion fires on pipe_wb_v_i & stall_pipe_o.
- Other assertions:
  - No enqueue when full.
  - Count never exceeds els_p.
  - idiv_v_i must stay high with stable payload until yumi; this is checked.
- Reset mid-operation: queued results are discarded and the wait counter and stall clear. The divider and scoreboard are reset by the same reset.
- FSM: none beyond the count/stall flag. The stall flag has two states, IDLE and FORCE, with the transitions above.

Decomposition:
- bsg_vanilla_pkg gains:
  - idiv_wb_entry_s {rd, data} struct.
  - Constant idiv_wb_max_wait_gp = 8.
- Natural sub-module: idiv_wb_queue. It is a small 1r1w circular buffer with count, full/empty and async active-low reset.
- The arbitration, wait counter and stall flag live in the top.

Test Plan:
1. Reset is released with idle inputs: empty_o=1 and every other output 0. reset_n_i dropped mid-cycle clears stall_pipe_o immediately.
2. Single result: rd=5, data=0x0000_0007, pipe_wb_v_i=0. Yumi occurs in cycle T; in T+1, wb_v_o=1, wb_rd_o=5, wb_data_o=7 and sb_clear_rd_o=5; in T+2, empty_o=1.
3. Fill: pipe_wb_v_i=1 held, three back-to-back results rd=1,2,3.
   - Yumi goes to rd=1 and rd=2 only; rd=3 is held and idiv_yumi_o=0.
   - Releasing pipe_wb_v_i gives writes in order 1, 2, then 3.
4. Simultaneous: count=1 and idiv_v_i=1 while a dequeue occurs in the same cycle. The dequeue of the head and the enqueue both happen and count stays 1. Pointers wrap correctly over ≥4 iterations at els_p=2.
5. Starvation: one entry queued and pipe_wb_v_i=1 for 8 cycles.
   - stall_pipe_o rises on the 9th cycle.
   - The bench drops pipe_wb_v_i, wb_v_o=1, and stall_pipe_o falls the next cycle.
6. Protocol violation: pipe_wb_v_i=1 while stall_pipe_o=1. The assertion fires and wb_v_o stays 0.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared types and constants for the vanilla core integer divider writeback path.
//   reg_data_width_gp   : integer register width
//   reg_addr_width_gp   : integer register index width
//   idiv_wb_max_wait_gp : blocked cycles tolerated before the pipeline is stalled
//   idiv_wb_entry_s     : one buffered divider result {rd, data}
//   idiv_wb_stall_e     : stall flag state (idle / forcing a pipeline writeback bubble)
package bsg_vanilla_pkg;

  localparam int unsigned reg_data_width_gp   = 32;
  localparam int unsigned reg_addr_width_gp   = 5;
  localparam int unsigned idiv_wb_max_wait_gp = 8;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
    logic [reg_data_width_gp-1:0] data;
  } idiv_wb_entry_s;

  typedef enum logic {
    StIdle,
    StForce
  } idiv_wb_stall_e;

endpackage

// File: rtl/idiv_wb_queue.sv
// Small 1r1w circular buffer with occupancy count.
//   clk_i, reset_n_i : clock, asynchronous active-low reset (clears pointers/count)
//   enq_i, data_i    : write data_i at the tail (caller guarantees not full)
//   deq_i            : drop the head entry (caller guarantees not empty)
//   data_o           : head entry (raw storage, undefined while empty)
//   full_o, empty_o  : occupancy flags from the registered count
module idiv_wb_queue #(
  parameter int unsigned width_p = 37,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_lp      = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_i) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
    if (deq_i) rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == els_lp);
  assign empty_o = (count_q == '0);

`ifndef SYNTHESIS
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(enq_i && full_o))
    else $error("idiv_wb_queue: enqueue while full");
  a_count_range: assert property (@(posedge clk_i) disable iff (!reset_n_i) count_q <= els_lp)
    else $error("idiv_wb_queue: count above depth");
`endif

endmodule

// File: rtl/idiv_wb_buffer.sv
// Writeback buffer between the iterative divider and the integer regfile write port.
//   clk_i, reset_n_i              : clock, asynchronous active-low reset
//   idiv_v_i/rd_i/result_i        : divider result stream, idiv_yumi_o consumes it
//   pipe_wb_v_i                   : main pipeline owns the write port this cycle (has priority)
//   wb_v_o/wb_rd_o/wb_data_o      : buffered regfile write (rd/data are zero while empty)
//   sb_clear_v_o/sb_clear_rd_o    : scoreboard clear, same cycle as the write
//   stall_pipe_o                  : pipeline must skip writeback next cycle (anti-starvation)
//   empty_o                       : buffer empty, used for fence/drain
module idiv_wb_buffer
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned data_width_p     = reg_data_width_gp,
  parameter int unsigned reg_addr_width_p = reg_addr_width_gp,
  parameter int unsigned els_p            = 2,
  parameter int unsigned max_wait_p       = idiv_wb_max_wait_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        idiv_v_i,
  input  logic [reg_addr_width_p-1:0] idiv_rd_i,
  input  logic [data_width_p-1:0]     idiv_result_i,
  output logic                        idiv_yumi_o,
  input  logic                        pipe_wb_v_i,
  output logic                        wb_v_o,
  output logic [reg_addr_width_p-1:0] wb_rd_o,
  output logic [data_width_p-1:0]     wb_data_o,
  output logic                        sb_clear_v_o,
  output logic [reg_addr_width_p-1:0] sb_clear_rd_o,
  output logic                        stall_pipe_o,
  output logic                        empty_o
);

  localparam int unsigned entry_width_lp = reg_addr_width_p + data_width_p;
  localparam int unsigned wait_width_lp  = $clog2(max_wait_p + 1);
  localparam logic [wait_width_lp-1:0] max_wait_lp = wait_width_lp'(max_wait_p);

  logic [entry_width_lp-1:0] head;
  logic                      q_full, q_empty;
  logic [wait_width_lp-1:0]  wait_q, wait_d;
  idiv_wb_stall_e            state_q, state_d;

  // Full comes from the registered count, so a same-cycle dequeue never frees a slot.
  assign idiv_yumi_o = idiv_v_i & ~q_full;
  assign wb_v_o      = ~q_empty & ~pipe_wb_v_i;

  idiv_wb_queue #(
    .width_p (entry_width_lp),
    .els_p   (els_p)
  ) u_queue (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (idiv_yumi_o),
    .data_i    ({idiv_rd_i, idiv_result_i}),
    .deq_i     (wb_v_o),
    .data_o    (head),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  // Mask uninitialised storage so the write bus is quiet while empty.
  assign {wb_rd_o, wb_data_o} = q_empty ? '0 : head;
  assign sb_clear_v_o         = wb_v_o;
  assign sb_clear_rd_o        = wb_rd_o;
  assign empty_o              = q_empty;

  // Counts consecutive cycles the head was ready but lost the port; saturates.
  always_comb begin
    wait_d = wait_q;
    if (q_empty || wb_v_o) begin
      wait_d = '0;
    end else if (pipe_wb_v_i && (wait_q != max_wait_lp)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (wait_d == max_wait_lp) state_d = StForce;
      StForce: if (wb_v_o || q_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q  <= '0;
      state_q <= StIdle;
    end else begin
      wait_q  <= wait_d;
      state_q <= state_d;
    end
  end

  assign stall_pipe_o = (state_q == StForce);

`ifndef SYNTHESIS
  // The pipeline still wins if it ignores the stall; flag it but keep running.
  a_stall_honoured: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(pipe_wb_v_i && stall_pipe_o))
    else $warning("idiv_wb_buffer: pipe_wb_v_i high while stall_pipe_o is set");
  a_idiv_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (idiv_v_i && !idiv_yumi_o) |=>
      (idiv_v_i && $stable(idiv_rd_i) && $stable(idiv_result_i)))
    else $error("idiv_wb_buffer: divider result dropped or changed before yumi");
`endif

endmodule

// File: tb/tb_idiv_wb_buffer.sv
module tb_idiv_wb_buffer;
  import bsg_vanilla_pkg::*;

  localparam int ELS  = 2;
  localparam int MAXW = idiv_wb_max_wait_gp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idiv_v = 1'b0;
  logic [4:0]  idiv_rd = '0;
  logic [31:0] idiv_result = '0;
  logic        idiv_yumi;
  logic        pipe_wb_v = 1'b0;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sb_clear_v;
  logic [4:0]  sb_clear_rd;
  logic        stall_pipe;
  logic        empty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit drv_done = 1'b0;

  // Reference model: occupancy, blocked-streak length, stall flag, expected write order.
  int             m_cnt = 0;
  int             m_wait = 0;
  bit             m_stall = 1'b0;
  idiv_wb_entry_s sb_q[$];

  idiv_wb_buffer #(
    .data_width_p     (32),
    .reg_addr_width_p (5),
    .els_p            (ELS),
    .max_wait_p       (MAXW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .idiv_v_i      (idiv_v),
    .idiv_rd_i     (idiv_rd),
    .idiv_result_i (idiv_result),
    .idiv_yumi_o   (idiv_yumi),
    .pipe_wb_v_i   (pipe_wb_v),
    .wb_v_o        (wb_v),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .sb_clear_v_o  (sb_clear_v),
    .sb_clear_rd_o (sb_clear_rd),
    .stall_pipe_o  (stall_pipe),
    .empty_o       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT samples; reset clears everything at once.
  always @(posedge clk or negedge rst_n) begin : mdl
    bit acc, wr;
    int nc, nw;
    bit ns;
    if (!rst_n) begin
      m_cnt   <= 0;
      m_wait  <= 0;
      m_stall <= 1'b0;
      sb_q.delete();
    end else begin
      acc = idiv_v && (m_cnt < ELS);
      wr  = (m_cnt > 0) && !pipe_wb_v;
      if (acc) sb_q.push_back('{rd: idiv_rd, data: idiv_result});
      nc = m_cnt + (acc ? 1 : 0) - (wr ? 1 : 0);
      if (m_cnt == 0 || wr) nw = 0;
      else nw = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      if (m_cnt == 0 || wr) ns = 1'b0;
      else if (nw == MAXW) ns = 1'b1;
      else ns = m_stall;
      m_cnt   <= nc;
      m_wait  <= nw;
      m_stall <= ns;
    end
  end

  // Control-signal checks against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("yumi", 64'(idiv_yumi), 64'(idiv_v && (m_cnt < ELS)));
      chk("wb_v", 64'(wb_v), 64'((m_cnt > 0) && !pipe_wb_v));
      chk("sb_clear_v", 64'(sb_clear_v), 64'((m_cnt > 0) && !pipe_wb_v));
      chk("empty", 64'(empty), 64'(m_cnt == 0));
      chk("stall", 64'(stall_pipe), 64'(m_stall));
      if (m_cnt == 0) chk("idle_bus", 64'({wb_rd, wb_data}), 64'(0));
    end
  end

  // Scoreboard monitor: every DUT write must match the next accepted result.
  always @(negedge clk) begin
    if (chk_en && wb_v === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 64'(1), 64'(0));
      end else begin
        idiv_wb_entry_s e;
        e = sb_q.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("sb_clear_rd", 64'(sb_clear_rd), 64'(e.rd));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a result and hold it until consumed; returns just after the consuming edge.
  task automatic send(input logic [4:0] rd, input logic [31:0] data);
    bit got;
    int n;
    idiv_v = 1'b1;
    idiv_rd = rd;
    idiv_result = data;
    n = 0;
    got = 1'b0;
    do begin
      @(negedge clk);
      got = idiv_yumi;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    if (!got) chk("yumi_timeout", 64'(0), 64'(1));
    idiv_v = 1'b0;
  endtask

  initial begin
    // 1: reset with idle inputs
    cyc(3);
    rst_n = 1'b1;
    #1;
    chk_en = 1'b1;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_outs", 64'({idiv_yumi, wb_v, sb_clear_v, stall_pipe}), 64'(0));
    cyc(2);

    // 2: single result, written the cycle after yumi
    send(5'd5, 32'h0000_0007);
    chk("single_wb_v", 64'(wb_v), 64'(1));
    chk("single_rd", 64'(wb_rd), 64'(5));
    chk("single_data", 64'(wb_data), 64'(7));
    cyc(1);
    chk("single_empty", 64'(empty), 64'(1));
    cyc(2);

    // 3: fill while the pipeline owns the port
    pipe_wb_v = 1'b1;
    fork
      begin
        send(5'd1, 32'h11);
        send(5'd2, 32'h22);
        send(5'd3, 32'h33);
      end
      begin
        cyc(3);
        chk("fill_hold", 64'(idiv_yumi), 64'(0));
        chk("fill_rd3", 64'(idiv_rd), 64'(3));
        pipe_wb_v = 1'b0;
      end
    join
    cyc(4);

    // 4: back-to-back stream, enqueue and dequeue together with wrapping pointers
    for (int i = 0; i < 7; i++) send(5'(i + 8), 32'hA000_0000 + 32'(i));
    cyc(4);

    // 5 and 6: starvation, then the pipeline ignores the stall for one cycle
    pipe_wb_v = 1'b1;
    send(5'd0, 32'hDEAD_BEEF);
    cyc(7);
    chk("stall_early", 64'(stall_pipe), 64'(0));
    cyc(1);
    chk("stall_rise", 64'(stall_pipe), 64'(1));
    chk("viol_wb_v", 64'(wb_v), 64'(0));
    cyc(1);
    chk("viol_stall_held", 64'(stall_pipe), 64'(1));
    pipe_wb_v = 1'b0;
    #1;
    chk("release_wb_v", 64'(wb_v), 64'(1));
    cyc(1);
    chk("stall_fall", 64'(stall_pipe), 64'(0));
    cyc(2);

    // 1b: asynchronous reset mid-cycle clears a raised stall immediately
    pipe_wb_v = 1'b1;
    send(5'd7, 32'h1234_5678);
    cyc(8);
    chk("stall_pre_rst", 64'(stall_pipe), 64'(1));
    pipe_wb_v = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 64'(stall_pipe), 64'(0));
    chk("async_rst_empty", 64'(empty), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);

    // Randomised traffic with a pipeline that honours the stall
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
          send(5'($urandom_range(0, 31)), $urandom);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          pipe_wb_v = stall_pipe ? 1'b0 : ($urandom_range(0, 99) < 65);
          cyc(1);
        end
      end
    join
    pipe_wb_v = 1'b0;
    cyc(6);
    chk("drain_sb", 64'(sb_q.size()), 64'(0));
    chk("drain_empty", 64'(empty), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
